// File: rtl/fmul32.sv
// Three-stage pipelined binary32 multiplier with negate/abs/square variants.
// Subnormal inputs flush to zero; results that underflow flush to signed zero.
module fmul32 #(
  parameter int DATA_W        = 32,
  parameter int OPERATION_NUM = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_W-1:0]                op1,
  input  logic [DATA_W-1:0]                op2,
  input  logic [$clog2(OPERATION_NUM)-1:0] opc,
  input  logic [1:0]                       r_mode,
  input  logic                             in_valid,
  output logic [DATA_W-1:0]                res,
  output logic [3:0]                       flags,
  output logic                             out_valid
);

  localparam int OPC_W = $clog2(OPERATION_NUM);
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;
  localparam logic [30:0] MAX_MAG = 31'h7F7F_FFFF;

  // Stage 1: operand classification
  logic [DATA_W-1:0] op_b;
  logic [7:0]        exp_a, exp_b;
  logic [22:0]       frac_a, frac_b;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic              any_nan, inf_zero;

  assign op_b     = (opc == OPC_W'(3)) ? op1 : op2;
  assign exp_a    = op1[30:23];
  assign exp_b    = op_b[30:23];
  assign frac_a   = op1[22:0];
  assign frac_b   = op_b[22:0];
  assign a_zero   = (exp_a == 8'd0);
  assign b_zero   = (exp_b == 8'd0);
  assign a_inf    = (exp_a == 8'hFF) && (frac_a == 23'd0);
  assign b_inf    = (exp_b == 8'hFF) && (frac_b == 23'd0);
  assign a_nan    = (exp_a == 8'hFF) && (frac_a != 23'd0);
  assign b_nan    = (exp_b == 8'hFF) && (frac_b != 23'd0);
  assign a_snan   = a_nan && !frac_a[22];
  assign b_snan   = b_nan && !frac_b[22];
  assign any_nan  = a_nan || b_nan;
  assign inf_zero = (a_inf && b_zero) || (a_zero && b_inf);

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q, s1_sign_d;
  logic [9:0]       s1_exp_q, s1_exp_d;
  logic [23:0]      s1_man_a_q, s1_man_a_d;
  logic [23:0]      s1_man_b_q, s1_man_b_d;
  logic             s1_special_q, s1_special_d;
  logic             s1_spec_nan_q, s1_spec_nan_d;
  logic             s1_spec_inf_q, s1_spec_inf_d;
  logic             s1_nv_q, s1_nv_d;
  logic [OPC_W-1:0] s1_opc_q, s1_opc_d;
  logic [1:0]       s1_rmode_q, s1_rmode_d;

  // Data registers only load on a valid operation so idle-cycle inputs never leak in.
  always_comb begin
    s1_valid_d    = in_valid;
    s1_sign_d     = s1_sign_q;
    s1_exp_d      = s1_exp_q;
    s1_man_a_d    = s1_man_a_q;
    s1_man_b_d    = s1_man_b_q;
    s1_special_d  = s1_special_q;
    s1_spec_nan_d = s1_spec_nan_q;
    s1_spec_inf_d = s1_spec_inf_q;
    s1_nv_d       = s1_nv_q;
    s1_opc_d      = s1_opc_q;
    s1_rmode_d    = s1_rmode_q;
    if (in_valid) begin
      s1_sign_d     = op1[31] ^ op_b[31];
      s1_exp_d      = {2'b00, exp_a} + {2'b00, exp_b} - 10'd127;
      s1_man_a_d    = {1'b1, frac_a};
      s1_man_b_d    = {1'b1, frac_b};
      s1_special_d  = any_nan || a_inf || b_inf || a_zero || b_zero;
      s1_spec_nan_d = any_nan || inf_zero;
      s1_spec_inf_d = a_inf || b_inf;
      s1_nv_d       = a_snan || b_snan || inf_zero;
      s1_opc_d      = opc;
      s1_rmode_d    = r_mode;
    end
  end

  // Stage 2: significand product
  logic             s2_valid_q, s2_valid_d;
  logic             s2_sign_q, s2_sign_d;
  logic [9:0]       s2_exp_q, s2_exp_d;
  logic [47:0]      s2_prod_q, s2_prod_d;
  logic             s2_special_q, s2_special_d;
  logic             s2_spec_nan_q, s2_spec_nan_d;
  logic             s2_spec_inf_q, s2_spec_inf_d;
  logic             s2_nv_q, s2_nv_d;
  logic [OPC_W-1:0] s2_opc_q, s2_opc_d;
  logic [1:0]       s2_rmode_q, s2_rmode_d;

  always_comb begin
    s2_valid_d    = s1_valid_q;
    s2_sign_d     = s2_sign_q;
    s2_exp_d      = s2_exp_q;
    s2_prod_d     = s2_prod_q;
    s2_special_d  = s2_special_q;
    s2_spec_nan_d = s2_spec_nan_q;
    s2_spec_inf_d = s2_spec_inf_q;
    s2_nv_d       = s2_nv_q;
    s2_opc_d      = s2_opc_q;
    s2_rmode_d    = s2_rmode_q;
    if (s1_valid_q) begin
      s2_sign_d     = s1_sign_q;
      s2_exp_d      = s1_exp_q;
      s2_prod_d     = {24'd0, s1_man_a_q} * {24'd0, s1_man_b_q};
      s2_special_d  = s1_special_q;
      s2_spec_nan_d = s1_spec_nan_q;
      s2_spec_inf_d = s1_spec_inf_q;
      s2_nv_d       = s1_nv_q;
      s2_opc_d      = s1_opc_q;
      s2_rmode_d    = s1_rmode_q;
    end
  end

  // Stage 3: normalize, round, pack
  logic        norm_hi, guard_bit, round_bit, sticky_bit, inexact, round_inc;
  logic        final_sign, underflow, overflow, ovf_to_inf;
  logic [23:0] mant;
  logic [24:0] mant_r;
  logic [22:0] frac_out;
  logic [9:0]  exp_n, exp_r;

  always_comb begin
    norm_hi    = s2_prod_q[47];
    mant       = norm_hi ? s2_prod_q[47:24] : s2_prod_q[46:23];
    guard_bit  = norm_hi ? s2_prod_q[23] : s2_prod_q[22];
    round_bit  = norm_hi ? s2_prod_q[22] : s2_prod_q[21];
    sticky_bit = norm_hi ? (|s2_prod_q[21:0]) : (|s2_prod_q[20:0]);
    exp_n      = s2_exp_q + {9'd0, norm_hi};
    inexact    = guard_bit | round_bit | sticky_bit;

    // Directed rounding must see the sign the result will actually carry.
    case (s2_opc_q)
      OPC_W'(1): final_sign = ~s2_sign_q;
      OPC_W'(2): final_sign = 1'b0;
      default:   final_sign = s2_sign_q;
    endcase

    case (s2_rmode_q)
      2'd0:    round_inc = guard_bit & (round_bit | sticky_bit | mant[0]);
      2'd2:    round_inc = inexact & ~final_sign;
      2'd3:    round_inc = inexact & final_sign;
      default: round_inc = 1'b0;
    endcase

    mant_r     = {1'b0, mant} + {24'd0, round_inc};
    exp_r      = exp_n + {9'd0, mant_r[24]};
    frac_out   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    underflow  = $signed(exp_n) < 10'sd1;
    overflow   = $signed(exp_r) > 10'sd254;
    ovf_to_inf = (s2_rmode_q == 2'd0) ||
                 ((s2_rmode_q == 2'd2) && !final_sign) ||
                 ((s2_rmode_q == 2'd3) && final_sign);
  end

  logic [31:0] res_q, res_d;
  logic [3:0]  flags_q, flags_d;
  logic        out_valid_q, out_valid_d;

  always_comb begin
    out_valid_d = s2_valid_q;
    res_d       = res_q;
    flags_d     = flags_q;
    if (s2_valid_q) begin
      if (s2_special_q) begin
        if (s2_spec_nan_q) begin
          res_d   = QNAN;
          flags_d = {s2_nv_q, 3'b000};
        end else begin
          res_d   = {final_sign, s2_spec_inf_q ? INF_MAG : 31'd0};
          flags_d = 4'b0000;
        end
      end else if (underflow) begin
        res_d   = {final_sign, 31'd0};
        flags_d = 4'b0011;
      end else if (overflow) begin
        res_d   = {final_sign, ovf_to_inf ? INF_MAG : MAX_MAG};
        flags_d = 4'b0101;
      end else begin
        res_d   = {final_sign, exp_r[7:0], frac_out};
        flags_d = {3'b000, inexact};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_man_a_q    <= '0;
      s1_man_b_q    <= '0;
      s1_special_q  <= 1'b0;
      s1_spec_nan_q <= 1'b0;
      s1_spec_inf_q <= 1'b0;
      s1_nv_q       <= 1'b0;
      s1_opc_q      <= '0;
      s1_rmode_q    <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_exp_q      <= '0;
      s2_prod_q     <= '0;
      s2_special_q  <= 1'b0;
      s2_spec_nan_q <= 1'b0;
      s2_spec_inf_q <= 1'b0;
      s2_nv_q       <= 1'b0;
      s2_opc_q      <= '0;
      s2_rmode_q    <= '0;
      res_q         <= '0;
      flags_q       <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_exp_q      <= s1_exp_d;
      s1_man_a_q    <= s1_man_a_d;
      s1_man_b_q    <= s1_man_b_d;
      s1_special_q  <= s1_special_d;
      s1_spec_nan_q <= s1_spec_nan_d;
      s1_spec_inf_q <= s1_spec_inf_d;
      s1_nv_q       <= s1_nv_d;
      s1_opc_q      <= s1_opc_d;
      s1_rmode_q    <= s1_rmode_d;
      s2_valid_q    <= s2_valid_d;
      s2_sign_q     <= s2_sign_d;
      s2_exp_q      <= s2_exp_d;
      s2_prod_q     <= s2_prod_d;
      s2_special_q  <= s2_special_d;
      s2_spec_nan_q <= s2_spec_nan_d;
      s2_spec_inf_q <= s2_spec_inf_d;
      s2_nv_q       <= s2_nv_d;
      s2_opc_q      <= s2_opc_d;
      s2_rmode_q    <= s2_rmode_d;
      res_q         <= res_d;
      flags_q       <= flags_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign res       = res_q;
  assign flags     = flags_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fmul32.sv
// Self-checking bench for fmul32: directed spec vectors plus randomized traffic
// compared against an integer-arithmetic reference of binary32 multiplication.
module tb_fmul32;

  logic        clk;
  logic        rst_n;
  logic [31:0] op1, op2;
  logic [1:0]  opc, r_mode;
  logic        in_valid;
  logic [31:0] res;
  logic [3:0]  flags;
  logic        out_valid;

  int total;
  int bad;

  logic [31:0] last_res;
  logic [3:0]  last_flags;

  bit          q_v[$];
  logic [31:0] q_res[$];
  logic [3:0]  q_flags[$];
  string       q_tag[$];

  fmul32 dut (
    .clk(clk), .rst_n(rst_n), .op1(op1), .op2(op2), .opc(opc), .r_mode(r_mode),
    .in_valid(in_valid), .res(res), .flags(flags), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product, rounding decided by comparing the
  // discarded remainder with half an ulp.
  function automatic logic [35:0] refMul(input logic [31:0] a, input logic [31:0] bIn,
                                         input logic [1:0] oc, input logic [1:0] rm);
    logic [31:0] b;
    bit     sgn, fsgn, anan, bnan, asnan, bsnan, ainf, binf, azero, bzero, up, inexact, toInf;
    int     ea, eb, e, sh;
    longint ma, mb, p, q, rem, half;
    b     = (oc == 2'd3) ? a : bIn;
    ea    = int'(a[30:23]);
    eb    = int'(b[30:23]);
    anan  = (ea == 255) && (a[22:0] != 0);
    bnan  = (eb == 255) && (b[22:0] != 0);
    asnan = anan && !a[22];
    bsnan = bnan && !b[22];
    ainf  = (ea == 255) && (a[22:0] == 0);
    binf  = (eb == 255) && (b[22:0] == 0);
    azero = (ea == 0);
    bzero = (eb == 0);
    sgn   = a[31] ^ b[31];
    fsgn  = (oc == 2'd1) ? !sgn : (oc == 2'd2) ? 1'b0 : sgn;
    if (anan || bnan) return {(asnan || bsnan) ? 4'b1000 : 4'b0000, 32'h7FC00000};
    if ((ainf && bzero) || (azero && binf)) return {4'b1000, 32'h7FC00000};
    if (ainf || binf) return {4'b0000, fsgn, 31'h7F800000};
    if (azero || bzero) return {4'b0000, fsgn, 31'h0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    p  = ma * mb;
    e  = ea + eb - 127;
    sh = 23;
    if (p >= (longint'(1) << 47)) begin
      e++;
      sh = 24;
    end
    if (e <= 0) return {4'b0011, fsgn, 31'h0};
    q       = p >> sh;
    rem     = p - (q << sh);
    half    = longint'(1) << (sh - 1);
    inexact = (rem != 0);
    case (rm)
      2'd0:    up = (rem > half) || ((rem == half) && (q % 2 == 1));
      2'd2:    up = inexact && !fsgn;
      2'd3:    up = inexact && fsgn;
      default: up = 1'b0;
    endcase
    if (up) q++;
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) begin
      toInf = (rm == 2'd0) || ((rm == 2'd2) && !fsgn) || ((rm == 2'd3) && fsgn);
      return {4'b0101, fsgn, toInf ? 31'h7F800000 : 31'h7F7FFFFF};
    end
    return {3'b000, inexact, fsgn, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] randOperand();
    int kind;
    logic [31:0] v;
    kind = $urandom_range(0, 15);
    v    = $urandom;
    case (kind)
      0: begin
        case ($urandom_range(0, 5))
          0: v = 32'h00000000;
          1: v = 32'h80000000;
          2: v = {v[31], 31'h7F800000};
          3: v = 32'h7FC00001;
          4: v = 32'h7F900000;
          default: v = {v[31], 8'h00, v[22:0]};
        endcase
      end
      1, 2: v[30:23] = 8'($urandom_range(1, 254));
      default: v[30:23] = 8'($urandom_range(64, 190));
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, expv);
    end
  endtask

  // One clock step: check what should be at the output now, then drive the next input.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] oc, input logic [1:0] rm,
                      input logic [31:0] eres, input logic [3:0] efl, input string tag);
    bit    ev;
    string et;
    logic [31:0] er;
    logic [3:0]  ef;
    @(negedge clk);
    ev = q_v.pop_front();
    er = q_res.pop_front();
    ef = q_flags.pop_front();
    et = q_tag.pop_front();
    if (ev) begin
      last_res   = er;
      last_flags = ef;
    end
    checkOutput({et, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
    checkOutput({et, ".res"}, res, last_res);
    checkOutput({et, ".flags"}, {28'd0, flags}, {28'd0, last_flags});
    in_valid = v;
    op1      = a;
    op2      = b;
    opc      = oc;
    r_mode   = rm;
    q_v.push_back(v);
    q_res.push_back(eres);
    q_flags.push_back(efl);
    q_tag.push_back(tag);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] oc, input logic [1:0] rm, input string tag);
    logic [35:0] m;
    m = refMul(a, b, oc, rm);
    step(1'b1, a, b, oc, rm, m[31:0], m[35:32], tag);
  endtask

  task automatic applyDirected(input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] oc, input logic [1:0] rm,
                               input logic [31:0] eres, input logic [3:0] efl, input string tag);
    step(1'b1, a, b, oc, rm, eres, efl, tag);
  endtask

  task automatic applyIdle();
    step(1'b0, $urandom, $urandom, 2'($urandom), 2'($urandom), 32'd0, 4'd0, "idle");
  endtask

  task automatic clearPipeModel();
    q_v.delete();
    q_res.delete();
    q_flags.delete();
    q_tag.delete();
    for (int i = 0; i < 3; i++) begin
      q_v.push_back(1'b0);
      q_res.push_back(32'd0);
      q_flags.push_back(4'd0);
      q_tag.push_back("empty");
    end
    last_res   = 32'd0;
    last_flags = 4'd0;
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op1      = 32'd0;
    op2      = 32'd0;
    opc      = 2'd0;
    r_mode   = 2'd0;
    total    = 0;
    bad      = 0;
    clearPipeModel();

    repeat (2) @(negedge clk);
    checkOutput("reset.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset.res", res, 32'd0);
    checkOutput("reset.flags", {28'd0, flags}, 32'd0);
    rst_n = 1'b1;

    applyDirected(32'h3FC00000, 32'h40000000, 2'd0, 2'd0, 32'h40400000, 4'b0000, "mul");
    applyDirected(32'h3FC00000, 32'h40000000, 2'd1, 2'd0, 32'hC0400000, 4'b0000, "neg");
    applyDirected(32'hBFC00000, 32'h40000000, 2'd2, 2'd0, 32'h40400000, 4'b0000, "abs");
    applyDirected(32'h3F800001, 32'h12345678, 2'd3, 2'd0, 32'h3F800002, 4'b0001, "sq_rne");
    applyDirected(32'h3F800001, 32'hFFFFFFFF, 2'd3, 2'd1, 32'h3F800002, 4'b0001, "sq_rtz");
    applyDirected(32'h3F800001, 32'h00000000, 2'd3, 2'd2, 32'h3F800003, 4'b0001, "sq_rup");
    applyDirected(32'h3F800001, 32'h7FC00000, 2'd3, 2'd3, 32'h3F800002, 4'b0001, "sq_rdn");
    applyDirected(32'h1F9ED0EB, 32'h2001B86C, 2'd0, 2'd0, 32'h00000000, 4'b0011, "uflow");
    applyDirected(32'h7F000000, 32'h7F000000, 2'd0, 2'd0, 32'h7F800000, 4'b0101, "oflow_rne");
    applyDirected(32'h7F000000, 32'h7F000000, 2'd0, 2'd1, 32'h7F7FFFFF, 4'b0101, "oflow_rtz");
    applyDirected(32'h7F800000, 32'h00000000, 2'd0, 2'd0, 32'h7FC00000, 4'b1000, "inf_x_zero");
    applyDirected(32'h7FA00000, 32'h3F800000, 2'd0, 2'd0, 32'h7FC00000, 4'b1000, "snan");
    applyDirected(32'hFF800000, 32'h40000000, 2'd0, 2'd0, 32'hFF800000, 4'b0000, "inf_x_fin");
    applyDirected(32'h00000000, 32'hC0000000, 2'd1, 2'd2, 32'h00000000, 4'b0000, "zero_neg");
    repeat (3) applyIdle();

    for (int i = 0; i < 8; i++)
      applyStimulus(randOperand(), randOperand(), 2'(i), 2'(i / 2), $sformatf("b2b%0d", i));
    repeat (3) applyIdle();

    applyDirected(32'h3FC00000, 32'h40000000, 2'd0, 2'd0, 32'h40400000, 4'b0000, "pre_reset");
    repeat (3) applyIdle();
    applyStimulus(32'h3FC00000, 32'h40400000, 2'd0, 2'd0, "inflight0");
    applyStimulus(32'h40000000, 32'h40000000, 2'd1, 2'd1, "inflight1");
    applyStimulus(32'h7F000000, 32'h7F000000, 2'd0, 2'd0, "inflight2");
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("midreset.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midreset.res", res, 32'd0);
    checkOutput("midreset.flags", {28'd0, flags}, 32'd0);
    clearPipeModel();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) applyIdle();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) applyIdle();
      else applyStimulus(randOperand(), randOperand(), 2'($urandom), 2'($urandom),
                         $sformatf("rand%0d", i));
    end
    repeat (4) applyIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmul32.md
# fmul32

Pipelined IEEE-754 single-precision floating-point multiply unit for the datapath's FP execution slot. It takes two 32-bit operands, an operation code selecting one of four multiply variants, and a rounding mode. It returns a rounded 32-bit result plus exception flags after a fixed three-cycle latency. It accepts one new operation per cycle.

## Interface
- DATA_W, 32, operand/result width; only 32 is supported (binary32 format).
- OPERATION_NUM, 4, number of operation codes; opc width is clog2(OPERATION_NUM) = 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- op1  input  DATA_W  operand A (binary32).
- op2  input  DATA_W  operand B (binary32).
- opc  input  2  operation select, sampled together with the operands.
- r_mode  input  2  rounding mode, sampled together with the operands.
- in_valid  input  1  operands/opc/r_mode are valid this cycle.
- res  output  DATA_W  binary32 result.
- flags  output  4  {NV, OF, UF, NX}: invalid, overflow, underflow, inexact.
- out_valid  output  1  res/flags are valid this cycle.

## Operation
- opc 0: res = op1 × op2.
- opc 1: res = −(op1 × op2). Sign is inverted after rounding. For directed modes, rounding uses the final sign.
- opc 2: res = |op1 × op2|. The sign is forced to 0, including for NaN.
- opc 3: res = op1 × op1. op2 is ignored.
- r_mode 0: round to nearest, ties to even.
- r_mode 1: round toward zero.
- r_mode 2: round toward +∞.
- r_mode 3: round toward −∞.
- Sign of the product is sign(A) XOR sign(B), before the opc sign adjustment.
- Subnormal inputs (exponent field 0) are treated as signed zero. This flush-to-zero on input sets no flag.
- Normal path:
  - Significand product is the 24×24 → 48-bit product of the operands with the hidden 1 restored.
  - Biased exponent is eA + eB − 127, plus 1 if product bit 47 is set; normalize so the leading 1 lands in bit 47.
  - Round to 24 bits using guard, round and sticky bits.
  - A rounding carry-out increments the exponent.
- Overflow (biased exponent ≥ 255 after rounding):
  - Result is ±∞ for RNE and for the directed mode rounding away from the sign.
  - Otherwise result is ±0x7F7FFFFF (max finite).
  - Sets OF and NX.
- Underflow (biased exponent ≤ 0 before rounding): result flushes to signed zero (the opc sign rules still apply). Sets UF and NX.
- Special cases:
  - Any NaN operand gives the canonical NaN 0x7FC00000. NV is set only if an operand is a signaling NaN (quiet bit 0).
  - ∞ × 0 gives 0x7FC00000 with NV set.
  - ∞ × finite-nonzero or ∞ × ∞ gives ±∞ with no flags.
  - 0 × finite gives ±0 with no flags.
- NX is set whenever any discarded bit is nonzero on the normal path.
- Flags are per-operation, not sticky.

## Timing
- Stage 1 register: unpack, classify specials, compute sign and exponent sum, latch opc and r_mode.
- Stage 2 register: 48-bit significand product.
- Stage 3 register: normalize, round, pack, apply opc sign, produce flags.
- Latency: res, flags and out_valid appear 3 rising edges after the edge sampling in_valid=1.
- Throughput is 1 operation per cycle. There is no stall or backpressure.
- out_valid is in_valid delayed by 3 cycles.
- When out_valid=0, res and flags hold their previous values.
- Reset assertion (async): all pipeline valids, res and flags clear to 0 immediately. Any in-flight operations are discarded.
- After rst_n deasserts, the first operation may be presented on the next rising edge.
- If inputs are X while in_valid=0, outputs must not be corrupted.

## Test plan
- Reset: assert rst_n=0 mid-pipeline with 3 operations in flight → out_valid, res and flags read 0 at once; none of the in-flight operations ever emerge.
- Basic multiply and negate, RNE: op1=0x3FC00000, op2=0x40000000.
  - opc=0 → res=0x40400000, flags 0, 3 cycles later.
  - opc=1 → 0xC0400000.
  - opc=2 with op1=0xBFC00000 → 0x40400000.
- Rounding, opc=3, op1=0x3F800001:
  - r_mode 0 → 0x3F800002, NX.
  - r_mode 1 → 0x3F800002, NX.
  - r_mode 2 → 0x3F800003, NX.
  - r_mode 3 → 0x3F800002, NX.
- Underflow: op1=0x1F9ED0EB, op2=0x2001B86C, opc=0, r_mode=0 → res=0x00000000, flags UF|NX.
- Overflow and specials:
  - 0x7F000000 × 0x7F000000: RNE → 0x7F800000 with OF|NX; RTZ → 0x7F7FFFFF with OF|NX.
  - 0x7F800000 × 0x00000000 → 0x7FC00000 with NV.
  - 0x7FA00000 × 0x3F800000 → 0x7FC00000 with NV.
- Back-to-back: 8 consecutive valid operations with varying opc and r_mode → 8 consecutive out_valid cycles, results in order, each matching a reference model.
